// File: rtl/idu_opnd_fetch_pkg.sv
// Shared widths and the registered EXU bundle type for the IDU operand-fetch stage.
package idu_opnd_fetch_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_RF_DEPTH_BIT = 5;
  localparam int DEF_CTRL_WIDTH   = 16;
  localparam int SUPER_SCALAR_NUM = 2;

  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0]     pc;
    logic [DEF_DATA_WIDTH-1:0]   rs1_data;
    logic [DEF_DATA_WIDTH-1:0]   rs2_data;
    logic                        rd_wen;
    logic [DEF_RF_DEPTH_BIT-1:0] rd;
    logic [DEF_CTRL_WIDTH-1:0]   ctrl;
  } exu_bundle_t;

endpackage

// File: rtl/idu_opnd_fetch_if.sv
// Decode, register-file and EXU signals of the operand-fetch stage; slave is the stage's view.
interface idu_opnd_fetch_if
  import idu_opnd_fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int RF_DEPTH_BIT = DEF_RF_DEPTH_BIT,
  parameter int CTRL_WIDTH   = DEF_CTRL_WIDTH
);

  logic                    dec_of_vld      [SUPER_SCALAR_NUM-1:0];
  logic [PC_WIDTH-1:0]     dec_of_pc       [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] dec_of_rs1_idx  [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] dec_of_rs2_idx  [SUPER_SCALAR_NUM-1:0];
  logic                    dec_of_rd_wen   [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] dec_of_rd       [SUPER_SCALAR_NUM-1:0];
  logic [CTRL_WIDTH-1:0]   dec_of_ctrl     [SUPER_SCALAR_NUM-1:0];
  logic                    of_dec_acc      [SUPER_SCALAR_NUM-1:0];

  logic [RF_DEPTH_BIT-1:0] of_rf_rs1_idx   [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] of_rf_rs2_idx   [SUPER_SCALAR_NUM-1:0];
  logic [DATA_WIDTH-1:0]   rf_of_rs1_data  [SUPER_SCALAR_NUM-1:0];
  logic [DATA_WIDTH-1:0]   rf_of_rs2_data  [SUPER_SCALAR_NUM-1:0];
  logic                    rf_of_pipe_vld  [SUPER_SCALAR_NUM-1:0];
  logic                    rf_of_rd_vld    [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] rf_of_rd        [SUPER_SCALAR_NUM-1:0];
  logic [DATA_WIDTH-1:0]   rf_of_byp_data  [SUPER_SCALAR_NUM-1:0];

  logic                    of_exu_vld      [SUPER_SCALAR_NUM-1:0];
  logic [PC_WIDTH-1:0]     of_exu_pc       [SUPER_SCALAR_NUM-1:0];
  logic [DATA_WIDTH-1:0]   of_exu_rs1_data [SUPER_SCALAR_NUM-1:0];
  logic [DATA_WIDTH-1:0]   of_exu_rs2_data [SUPER_SCALAR_NUM-1:0];
  logic                    of_exu_rd_wen   [SUPER_SCALAR_NUM-1:0];
  logic [RF_DEPTH_BIT-1:0] of_exu_rd       [SUPER_SCALAR_NUM-1:0];
  logic [CTRL_WIDTH-1:0]   of_exu_ctrl     [SUPER_SCALAR_NUM-1:0];
  logic                    exu_of_rdy;

  modport slave (
    input  dec_of_vld, dec_of_pc, dec_of_rs1_idx, dec_of_rs2_idx,
           dec_of_rd_wen, dec_of_rd, dec_of_ctrl,
           rf_of_rs1_data, rf_of_rs2_data, rf_of_pipe_vld, rf_of_rd_vld,
           rf_of_rd, rf_of_byp_data, exu_of_rdy,
    output of_dec_acc, of_rf_rs1_idx, of_rf_rs2_idx,
           of_exu_vld, of_exu_pc, of_exu_rs1_data, of_exu_rs2_data,
           of_exu_rd_wen, of_exu_rd, of_exu_ctrl
  );

  modport master (
    output dec_of_vld, dec_of_pc, dec_of_rs1_idx, dec_of_rs2_idx,
           dec_of_rd_wen, dec_of_rd, dec_of_ctrl,
           rf_of_rs1_data, rf_of_rs2_data, rf_of_pipe_vld, rf_of_rd_vld,
           rf_of_rd, rf_of_byp_data, exu_of_rdy,
    input  of_dec_acc, of_rf_rs1_idx, of_rf_rs2_idx,
           of_exu_vld, of_exu_pc, of_exu_rs1_data, of_exu_rs2_data,
           of_exu_rd_wen, of_exu_rd, of_exu_ctrl
  );

endinterface

// File: rtl/idu_scoreboard.sv
// In-flight destination tracking: one pending bit per architectural register, x0 never pending.
module idu_scoreboard
  import idu_opnd_fetch_pkg::*;
#(
  parameter int RF_DEPTH_BIT = DEF_RF_DEPTH_BIT,
  parameter int NUM_SLOT     = SUPER_SCALAR_NUM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SLOT-1:0]       set_vld,
  input  logic [RF_DEPTH_BIT-1:0]   set_rd [NUM_SLOT-1:0],
  input  logic [NUM_SLOT-1:0]       clr_vld,
  input  logic [RF_DEPTH_BIT-1:0]   clr_rd [NUM_SLOT-1:0],
  output logic [(1<<RF_DEPTH_BIT)-1:0] eff
);

  localparam int NREG = 1 << RF_DEPTH_BIT;

  logic [NREG-1:1] pend_q, pend_d;
  logic [NREG-1:1] clr_vec, set_vec;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int k = 0; k < NUM_SLOT; k++) begin
      if (clr_vld[k] && clr_rd[k] != '0) clr_vec[clr_rd[k]] = 1'b1;
      if (set_vld[k] && set_rd[k] != '0) set_vec[set_rd[k]] = 1'b1;
    end
    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    pend_d = (pend_q & ~clr_vec) | set_vec;
    eff    = {pend_q & ~clr_vec, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/idu_opnd_fetch.sv
// Dual-issue operand fetch: bypass/RF operand select, hazard check, in-order accept and a one-deep EXU output stage.
module idu_opnd_fetch
  import idu_opnd_fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int RF_DEPTH_BIT = DEF_RF_DEPTH_BIT,
  parameter int CTRL_WIDTH   = DEF_CTRL_WIDTH
) (
  input logic             clk,
  input logic             rst,
  idu_opnd_fetch_if.slave bus
);

  localparam int NS   = SUPER_SCALAR_NUM;
  localparam int NREG = 1 << RF_DEPTH_BIT;

  logic [NREG-1:0]         eff;
  logic [NS-1:0]           set_vld, clr_vld;
  logic [RF_DEPTH_BIT-1:0] set_rd [NS-1:0];
  logic [RF_DEPTH_BIT-1:0] clr_rd [NS-1:0];

  logic                    out_free;
  logic [NS-1:0]           acc, haz, rs1_rdy, rs2_rdy;
  logic [DATA_WIDTH-1:0]   rs1_val [NS-1:0];
  logic [DATA_WIDTH-1:0]   rs2_val [NS-1:0];
  logic [1:0]              wb_vld;

  logic [NS-1:0]           vld_q, vld_d;
  exu_bundle_t             bundle_q [NS-1:0];
  exu_bundle_t             bundle_d [NS-1:0];

  // Returns {ready, data}; younger writeback slot 1 wins over slot 0.
  function automatic logic [DATA_WIDTH:0] resolve_src(
    input logic [RF_DEPTH_BIT-1:0] idx,
    input logic [DATA_WIDTH-1:0]   rf_data,
    input logic [1:0]              wbv,
    input logic [RF_DEPTH_BIT-1:0] wb_rd1,
    input logic [RF_DEPTH_BIT-1:0] wb_rd0,
    input logic [DATA_WIDTH-1:0]   wb_d1,
    input logic [DATA_WIDTH-1:0]   wb_d0,
    input logic                    pending
  );
    if (idx == '0)                    return {1'b1, {DATA_WIDTH{1'b0}}};
    else if (wbv[1] && wb_rd1 == idx) return {1'b1, wb_d1};
    else if (wbv[0] && wb_rd0 == idx) return {1'b1, wb_d0};
    else if (pending)                 return {1'b0, {DATA_WIDTH{1'b0}}};
    else                              return {1'b1, rf_data};
  endfunction

  always_comb begin
    wb_vld = {bus.rf_of_rd_vld[1], bus.rf_of_rd_vld[0]};
    for (int s = 0; s < NS; s++) begin
      {rs1_rdy[s], rs1_val[s]} = resolve_src(bus.dec_of_rs1_idx[s], bus.rf_of_rs1_data[s], wb_vld,
                                             bus.rf_of_rd[1], bus.rf_of_rd[0],
                                             bus.rf_of_byp_data[1], bus.rf_of_byp_data[0],
                                             eff[bus.dec_of_rs1_idx[s]]);
      {rs2_rdy[s], rs2_val[s]} = resolve_src(bus.dec_of_rs2_idx[s], bus.rf_of_rs2_data[s], wb_vld,
                                             bus.rf_of_rd[1], bus.rf_of_rd[0],
                                             bus.rf_of_byp_data[1], bus.rf_of_byp_data[0],
                                             eff[bus.dec_of_rs2_idx[s]]);
      haz[s] = !rs1_rdy[s] || !rs2_rdy[s] ||
               (bus.dec_of_rd_wen[s] && bus.dec_of_rd[s] != '0 && eff[bus.dec_of_rd[s]]);
    end
    // Slot 1 cannot see slot 0's result this cycle, so any overlap with slot 0's rd blocks it.
    if (bus.dec_of_rd_wen[0] && bus.dec_of_rd[0] != '0 &&
        (bus.dec_of_rs1_idx[1] == bus.dec_of_rd[0] ||
         bus.dec_of_rs2_idx[1] == bus.dec_of_rd[0] ||
         bus.dec_of_rd[1]      == bus.dec_of_rd[0]))
      haz[1] = 1'b1;

    out_free = !(|vld_q) || bus.exu_of_rdy;
    acc[0]   = !rst && bus.dec_of_vld[0] && out_free && !haz[0];
    acc[1]   = bus.dec_of_vld[1] && acc[0] && !haz[1];

    for (int s = 0; s < NS; s++) begin
      set_vld[s] = acc[s] && bus.dec_of_rd_wen[s];
      set_rd[s]  = bus.dec_of_rd[s];
      clr_vld[s] = bus.rf_of_rd_vld[s];
      clr_rd[s]  = bus.rf_of_rd[s];
    end
  end

  idu_scoreboard #(
    .RF_DEPTH_BIT (RF_DEPTH_BIT),
    .NUM_SLOT     (NS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_vld (set_vld),
    .set_rd  (set_rd),
    .clr_vld (clr_vld),
    .clr_rd  (clr_rd),
    .eff     (eff)
  );

  always_comb begin
    vld_d = vld_q;
    for (int s = 0; s < NS; s++) bundle_d[s] = bundle_q[s];
    if (out_free) begin
      vld_d = acc;
      for (int s = 0; s < NS; s++) begin
        bundle_d[s].pc       = bus.dec_of_pc[s];
        bundle_d[s].rs1_data = rs1_val[s];
        bundle_d[s].rs2_data = rs2_val[s];
        bundle_d[s].rd_wen   = bus.dec_of_rd_wen[s];
        bundle_d[s].rd       = bus.dec_of_rd[s];
        bundle_d[s].ctrl     = bus.dec_of_ctrl[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < NS; s++) bundle_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int s = 0; s < NS; s++) bundle_q[s] <= bundle_d[s];
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      bus.of_dec_acc[s]      = acc[s];
      bus.of_rf_rs1_idx[s]   = bus.dec_of_rs1_idx[s];
      bus.of_rf_rs2_idx[s]   = bus.dec_of_rs2_idx[s];
      bus.of_exu_vld[s]      = vld_q[s];
      bus.of_exu_pc[s]       = PC_WIDTH'(bundle_q[s].pc);
      bus.of_exu_rs1_data[s] = DATA_WIDTH'(bundle_q[s].rs1_data);
      bus.of_exu_rs2_data[s] = DATA_WIDTH'(bundle_q[s].rs2_data);
      bus.of_exu_rd_wen[s]   = bundle_q[s].rd_wen;
      bus.of_exu_rd[s]       = RF_DEPTH_BIT'(bundle_q[s].rd);
      bus.of_exu_ctrl[s]     = CTRL_WIDTH'(bundle_q[s].ctrl);
    end
  end

endmodule

// File: tb/tb_idu_opnd_fetch.sv
// Directed scenarios plus random traffic for idu_opnd_fetch against a per-cycle behavioural model.
module tb_idu_opnd_fetch;
  import idu_opnd_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idu_opnd_fetch_if bus ();
  idu_opnd_fetch dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] regs [32];

  // Model state
  bit          m_pend [32];
  bit          m_clr  [32];
  bit          m_vld  [2];
  logic [31:0] m_pc [2], m_rs1 [2], m_rs2 [2];
  bit          m_wen [2];
  logic [4:0]  m_rd [2];
  logic [15:0] m_ctrl [2];
  bit          m_all;
  bit          e_acc [2];
  bit          e_free;
  logic [31:0] e_rs1 [2], e_rs2 [2];
  logic [1:0]  last_acc;

  task automatic src_val(input logic [4:0] idx, input logic [31:0] rfd,
                         output bit ok, output logic [31:0] d);
    bit found = 0;
    ok = 1; d = 0;
    if (idx == 0) return;
    for (int k = 1; k >= 0; k--)
      if (!found && bus.rf_of_rd_vld[k] && bus.rf_of_rd[k] == idx) begin
        d = bus.rf_of_byp_data[k]; found = 1;
      end
    if (!found) begin
      if (m_pend[idx] && !m_clr[idx]) ok = 0;
      else d = rfd;
    end
  endtask

  task automatic model_comb();
    bit ok1, ok2;
    bit haz [2];
    for (int r = 0; r < 32; r++) m_clr[r] = 0;
    for (int k = 0; k < 2; k++) if (bus.rf_of_rd_vld[k]) m_clr[bus.rf_of_rd[k]] = 1;
    for (int s = 0; s < 2; s++) begin
      src_val(bus.dec_of_rs1_idx[s], bus.rf_of_rs1_data[s], ok1, e_rs1[s]);
      src_val(bus.dec_of_rs2_idx[s], bus.rf_of_rs2_data[s], ok2, e_rs2[s]);
      haz[s] = !ok1 || !ok2 ||
               (bus.dec_of_rd_wen[s] && bus.dec_of_rd[s] != 0 &&
                m_pend[bus.dec_of_rd[s]] && !m_clr[bus.dec_of_rd[s]]);
    end
    if (bus.dec_of_rd_wen[0] && bus.dec_of_rd[0] != 0 &&
        (bus.dec_of_rs1_idx[1] == bus.dec_of_rd[0] || bus.dec_of_rs2_idx[1] == bus.dec_of_rd[0] ||
         bus.dec_of_rd[1] == bus.dec_of_rd[0]))
      haz[1] = 1;
    e_free   = !(m_vld[0] || m_vld[1]) || bus.exu_of_rdy;
    e_acc[0] = !rst && bus.dec_of_vld[0] && e_free && !haz[0];
    e_acc[1] = bus.dec_of_vld[1] && e_acc[0] && !haz[1];
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      for (int s = 0; s < 2; s++) begin
        m_vld[s] = 0; m_pc[s] = 0; m_rs1[s] = 0; m_rs2[s] = 0;
        m_wen[s] = 0; m_rd[s] = 0; m_ctrl[s] = 0;
      end
      m_all = 1;
    end else begin
      m_all = 0;
      for (int k = 0; k < 2; k++) if (bus.rf_of_rd_vld[k]) m_pend[bus.rf_of_rd[k]] = 0;
      for (int s = 0; s < 2; s++)
        if (e_acc[s] && bus.dec_of_rd_wen[s] && bus.dec_of_rd[s] != 0) m_pend[bus.dec_of_rd[s]] = 1;
      if (e_free)
        for (int s = 0; s < 2; s++) begin
          m_vld[s] = e_acc[s]; m_pc[s] = bus.dec_of_pc[s];
          m_rs1[s] = e_rs1[s]; m_rs2[s] = e_rs2[s];
          m_wen[s] = bus.dec_of_rd_wen[s]; m_rd[s] = bus.dec_of_rd[s];
          m_ctrl[s] = bus.dec_of_ctrl[s];
        end
    end
  endtask

  task automatic step();
    logic [31:0] pm;
    #1;
    model_comb();
    last_acc = {bus.of_dec_acc[1], bus.of_dec_acc[0]};
    for (int s = 0; s < 2; s++) begin
      check($sformatf("acc%0d", s), bus.of_dec_acc[s], e_acc[s]);
      check($sformatf("rf_rs1_idx%0d", s), bus.of_rf_rs1_idx[s], bus.dec_of_rs1_idx[s]);
      check($sformatf("rf_rs2_idx%0d", s), bus.of_rf_rs2_idx[s], bus.dec_of_rs2_idx[s]);
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("exu_vld%0d", s), bus.of_exu_vld[s], m_vld[s]);
      if (m_vld[s] || m_all) begin
        check($sformatf("exu_pc%0d", s), bus.of_exu_pc[s], m_pc[s]);
        check($sformatf("exu_rs1%0d", s), bus.of_exu_rs1_data[s], m_rs1[s]);
        check($sformatf("exu_rs2%0d", s), bus.of_exu_rs2_data[s], m_rs2[s]);
        check($sformatf("exu_wen%0d", s), bus.of_exu_rd_wen[s], m_wen[s]);
        check($sformatf("exu_rd%0d", s), bus.of_exu_rd[s], m_rd[s]);
        check($sformatf("exu_ctrl%0d", s), bus.of_exu_ctrl[s], m_ctrl[s]);
      end
    end
    for (int r = 0; r < 32; r++) pm[r] = m_pend[r];
    check("pend", {dut.u_sb.pend_q, 1'b0}, pm);
    @(negedge clk);
  endtask

  task automatic drv_slot(input int s, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit wen, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [15:0] ctrl);
    bus.dec_of_vld[s] = v;       bus.dec_of_pc[s] = pc;
    bus.dec_of_rs1_idx[s] = rs1; bus.dec_of_rs2_idx[s] = rs2;
    bus.dec_of_rd_wen[s] = wen;  bus.dec_of_rd[s] = rd;
    bus.dec_of_ctrl[s] = ctrl;
    bus.rf_of_rs1_data[s] = regs[rs1];
    bus.rf_of_rs2_data[s] = regs[rs2];
  endtask

  task automatic drv_wb(input int k, input bit v, input logic [4:0] rd, input logic [31:0] d);
    bus.rf_of_pipe_vld[k] = v; bus.rf_of_rd_vld[k] = v;
    bus.rf_of_rd[k] = rd;      bus.rf_of_byp_data[k] = d;
  endtask

  task automatic idle();
    for (int s = 0; s < 2; s++) begin
      drv_slot(s, 0, 0, 0, 0, 0, 0, 0);
      drv_wb(s, 0, 0, 0);
    end
    bus.exu_of_rdy = 1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    rst = 1;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEAD_0000; regs[1] = 5; regs[2] = 7;
    idle();
    @(negedge clk);

    // Reset holds accept low even with a valid instruction presented
    drv_slot(0, 1, 1, 2, 1, 3, 32'h10, 16'h1);
    step();
    check("rst_acc", last_acc, 2'b00);
    check("rst_vld", {bus.of_exu_vld[1], bus.of_exu_vld[0]}, 2'b00);
    rst = 0;

    // Basic ADD
    idle();
    drv_slot(0, 1, 1, 2, 1, 3, 32'h1000, 16'h0001);
    step();
    check("t1_acc", last_acc, 2'b01);
    check("t1_vld", {bus.of_exu_vld[1], bus.of_exu_vld[0]}, 2'b01);
    check("t1_rs1", bus.of_exu_rs1_data[0], 32'd5);
    check("t1_rs2", bus.of_exu_rs2_data[0], 32'd7);
    check("t1_pend3", dut.u_sb.pend_q[3], 1'b1);

    // Intra-bundle RAW, then writeback bypass
    do_reset();
    drv_slot(0, 1, 0, 0, 1, 3, 32'h2000, 16'h2);
    drv_slot(1, 1, 3, 0, 1, 9, 32'h2004, 16'h3);
    step();
    check("t2_acc_a", last_acc, 2'b01);
    drv_slot(0, 1, 3, 0, 1, 9, 32'h2004, 16'h3);
    drv_slot(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t2_acc_b", last_acc, 2'b00);
    drv_wb(0, 1, 3, 32'hAB);
    step();
    check("t2_acc_c", last_acc, 2'b01);
    check("t2_rs1", bus.of_exu_rs1_data[0], 32'hAB);
    check("t2_pc", bus.of_exu_pc[0], 32'h2004);

    // Dual bypass of the same register: slot 1 wins
    do_reset();
    drv_slot(0, 1, 0, 0, 1, 4, 32'h3000, 16'h4);
    step();
    idle();
    drv_slot(0, 1, 4, 0, 0, 0, 32'h3004, 16'h5);
    drv_wb(0, 1, 4, 32'h11);
    drv_wb(1, 1, 4, 32'h22);
    step();
    check("t3_acc", last_acc, 2'b01);
    check("t3_rs1", bus.of_exu_rs1_data[0], 32'h22);

    // WAW stall released by writeback; set wins over clear
    do_reset();
    drv_slot(0, 1, 0, 0, 1, 5, 32'h4000, 16'h6);
    step();
    drv_slot(0, 1, 1, 0, 1, 5, 32'h4004, 16'h7);
    step();
    check("t4_acc_a", last_acc, 2'b00);
    drv_wb(0, 1, 5, 32'h55);
    step();
    check("t4_acc_b", last_acc, 2'b01);
    check("t4_pend5", dut.u_sb.pend_q[5], 1'b1);

    // Backpressure
    do_reset();
    drv_slot(0, 1, 0, 0, 0, 0, 32'h100, 16'h8);
    step();
    drv_slot(0, 1, 0, 0, 0, 0, 32'h200, 16'h9);
    bus.exu_of_rdy = 0;
    repeat (3) begin
      step();
      check("t5_acc_hold", last_acc, 2'b00);
      check("t5_pc_hold", bus.of_exu_pc[0], 32'h100);
    end
    bus.exu_of_rdy = 1;
    step();
    check("t5_acc_go", last_acc, 2'b01);
    check("t5_pc_go", bus.of_exu_pc[0], 32'h200);

    // Reset during a stall drops output and pending state
    drv_slot(0, 1, 0, 0, 1, 6, 32'h300, 16'hA);
    step();
    bus.exu_of_rdy = 0;
    drv_slot(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    step();
    rst = 0;
    check("t7_vld", bus.of_exu_vld[0], 1'b0);
    check("t7_pend6", dut.u_sb.pend_q[6], 1'b0);

    // x0 sources and rd=0 writer
    do_reset();
    drv_slot(0, 1, 0, 0, 1, 0, 32'h600, 16'hB);
    step();
    check("t6_acc", last_acc, 2'b01);
    check("t6_rs1", bus.of_exu_rs1_data[0], 32'h0);
    check("t6_rs2", bus.of_exu_rs2_data[0], 32'h0);
    check("t6_pend", {dut.u_sb.pend_q, 1'b0}, 32'h0);

    // Random traffic
    idle();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int s = 0; s < 2; s++) begin
        drv_slot(s, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 16'($urandom));
        drv_wb(s, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      end
      bus.exu_of_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
